// File: rtl/tt_hsig_pad_arbiter.sv
// tt_hsig_pad_arbiter: round-robin owner arbitration for one shared hsig pad cell, with bounded hold and forced OE-low turnaround
// Ports: clk, rst_n (async, active low); req/dir_out/dout [NREQ], pull_cfg [2*NREQ] ({pu,pd} per requester);
//        gnt [NREQ] one-hot grant, busy, din (synchronised pad_y); pad_y in; pad_a/oe/ie/sl/cs/pd/pu out (registered)
module tt_hsig_pad_arbiter #(
    parameter int   NREQ       = 4,
    parameter int   TURN_CYC   = 2,
    parameter int   MAX_HOLD   = 16,
    parameter logic SL_DEFAULT = 1'b0,
    parameter logic CS_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir_out,
    input  logic [NREQ-1:0]   dout,
    input  logic [2*NREQ-1:0] pull_cfg,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              din,
    input  logic              pad_y,
    output logic              pad_a,
    output logic              pad_oe,
    output logic              pad_ie,
    output logic              pad_sl,
    output logic              pad_cs,
    output logic              pad_pd,
    output logic              pad_pu
);
    localparam int PW   = $clog2(NREQ);
    // hold_cnt saturates at MAX_HOLD-1 so a late-arriving competitor still pre-empts a long owner
    localparam int HSAT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int HW   = (HSAT > 0) ? $clog2(HSAT + 1) : 1;
    localparam int TW   = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, idx;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]   turn_cnt_q, turn_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d, a_q, a_d, oe_q, oe_d, pd_q, pd_d, pu_q, pu_d;
    logic            sync_q, din_q, found, release_own;
    logic [1:0]      pull;

    // first requester after rr_ptr, searching upward with wrap
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign pull = pull_cfg[{owner_q, 1'b0} +: 2];
    assign release_own = !req[owner_q] ||
                         (MAX_HOLD != 0 && hold_cnt_q == HW'(HSAT) && (req & ~gnt_q) != '0);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        gnt_d      = gnt_q;
        a_d        = 1'b0;
        oe_d       = 1'b0;
        pd_d       = 1'b1;
        pu_d       = 1'b0;
        case (state_q)
            OWN: begin
                if (release_own) begin
                    state_d    = TURN;
                    gnt_d      = '0;
                    turn_cnt_d = '0;
                end else begin
                    a_d        = dout[owner_q];
                    oe_d       = dir_out[owner_q];
                    // both pulls on is illegal: release both instead
                    {pu_d, pd_d} = (pull == 2'b11) ? 2'b00 : pull;
                    hold_cnt_d = (hold_cnt_q == HW'(HSAT)) ? hold_cnt_q : hold_cnt_q + 1'b1;
                end
            end
            default: begin
                if (state_q == TURN && turn_cnt_q != TW'(TURN_CYC - 1)) begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end else if (found) begin
                    state_d    = OWN;
                    owner_d    = win;
                    rr_ptr_d   = win;
                    gnt_d      = NREQ'(1) << win;
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PW'(NREQ - 1);
            owner_q    <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            a_q        <= 1'b0;
            oe_q       <= 1'b0;
            pd_q       <= 1'b1;
            pu_q       <= 1'b0;
            sync_q     <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            a_q        <= a_d;
            oe_q       <= oe_d;
            pd_q       <= pd_d;
            pu_q       <= pu_d;
            sync_q     <= pad_y;
            din_q      <= sync_q;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign din    = din_q;
    assign pad_a  = a_q;
    assign pad_oe = oe_q;
    assign pad_ie = 1'b1;
    assign pad_sl = SL_DEFAULT;
    assign pad_cs = CS_DEFAULT;
    assign pad_pd = pd_q;
    assign pad_pu = pu_q;
endmodule

// File: tb/tb_tt_hsig_pad_arbiter.sv
// tb_tt_hsig_pad_arbiter: vector table, directed corner sequences and random traffic against a behavioural model
module tb_tt_hsig_pad_arbiter;
    localparam int   NREQ     = 4;
    localparam int   TURN_CYC = 2;
    localparam int   MAX_HOLD = 16;
    localparam logic SL_DEF   = 1'b0;
    localparam logic CS_DEF   = 1'b0;

    logic            clk = 1'b0, rst_n = 1'b0, pad_y = 1'b0;
    logic [NREQ-1:0] req = '0, dir_out = '0, dout = '0, gnt;
    logic [2*NREQ-1:0] pull_cfg = '0;
    logic busy, din, pad_a, pad_oe, pad_ie, pad_sl, pad_cs, pad_pd, pad_pu;

    int n_cmp = 0, n_bad = 0;

    tt_hsig_pad_arbiter #(.NREQ(NREQ), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD),
                          .SL_DEFAULT(SL_DEF), .CS_DEFAULT(CS_DEF)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dir_out(dir_out), .dout(dout), .pull_cfg(pull_cfg),
        .gnt(gnt), .busy(busy), .din(din), .pad_y(pad_y), .pad_a(pad_a), .pad_oe(pad_oe),
        .pad_ie(pad_ie), .pad_sl(pad_sl), .pad_cs(pad_cs), .pad_pd(pad_pd), .pad_pu(pad_pu)
    );

    always #5 clk = ~clk;

    // model: current owner (-1 = none), gap cycles left, cycles held, last winner, din history
    int m_own, m_gap, m_held, m_ptr;
    logic [NREQ-1:0] e_gnt;
    logic e_busy, e_a, e_oe, e_pd, e_pu;
    logic yq[$];

    function automatic void model_reset();
        m_own = -1; m_gap = 0; m_held = 0; m_ptr = NREQ - 1;
        e_gnt = '0; e_busy = 1'b0; e_a = 1'b0; e_oe = 1'b0; e_pd = 1'b1; e_pu = 1'b0;
        yq = {1'b0, 1'b0};
    endfunction

    function automatic void arbitrate();
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) begin
                m_own = (m_ptr + k) % NREQ;
                m_ptr = m_own;
                m_held = 0;
                break;
            end
        end
    endfunction

    function automatic void model_step();
        logic [NREQ-1:0] others;
        e_a = 1'b0; e_oe = 1'b0; e_pd = 1'b1; e_pu = 1'b0;
        if (m_own >= 0) begin
            others = req;
            others[m_own] = 1'b0;
            if (!req[m_own] || (MAX_HOLD != 0 && m_held >= MAX_HOLD - 1 && others != '0)) begin
                m_own = -1;
                m_gap = TURN_CYC;
            end else begin
                m_held++;
                e_a  = dout[m_own];
                e_oe = dir_out[m_own];
                if (pull_cfg[2*m_own +: 2] != 2'b11) begin
                    e_pu = pull_cfg[2*m_own+1];
                    e_pd = pull_cfg[2*m_own];
                end else begin
                    e_pd = 1'b0;
                end
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0) arbitrate();
        end
        e_gnt = '0;
        if (m_own >= 0) e_gnt[m_own] = 1'b1;
        e_busy = (m_own >= 0) || (m_gap > 0);
        void'(yq.pop_front());
        yq.push_back(pad_y);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("gnt", 8'(gnt), 8'(e_gnt));
        chk("busy", 8'(busy), 8'(e_busy));
        chk("pad_a", 8'(pad_a), 8'(e_a));
        chk("pad_oe", 8'(pad_oe), 8'(e_oe));
        chk("pad_pd", 8'(pad_pd), 8'(e_pd));
        chk("pad_pu", 8'(pad_pu), 8'(e_pu));
        chk("pad_ie", 8'(pad_ie), 8'd1);
        chk("pad_sl", 8'(pad_sl), 8'(SL_DEF));
        chk("pad_cs", 8'(pad_cs), 8'(CS_DEF));
        chk("din", 8'(din), 8'(yq[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic [NREQ-1:0]   req, dir, dout;
        logic [2*NREQ-1:0] pull;
        logic [NREQ-1:0]   g;
        logic              bsy, oe, a, pd, pu;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int t, own, gap, n2;
        int ord[$];
        int gaps[$];
        int run;
        logic [NREQ-1:0] last;

        tbl[0] = '{4'b0010, 4'b0010, 4'b0010, 8'h08, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'b0010, 4'b0010, 4'b0010, 8'h08, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{4'b0010, 4'b0010, 4'b0010, 8'h0C, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4'b0010, 4'b0010, 4'b0000, 8'h04, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{4'b0010, 4'b0000, 4'b0000, 8'h04, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        do_reset();
        chk("rst_gnt", 8'(gnt), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_oe", 8'(pad_oe), 8'd0);
        chk("rst_a", 8'(pad_a), 8'd0);
        chk("rst_ie", 8'(pad_ie), 8'd1);
        chk("rst_pd", 8'(pad_pd), 8'd1);
        chk("rst_pu", 8'(pad_pu), 8'd0);
        chk("rst_sl", 8'(pad_sl), 8'(SL_DEF));
        chk("rst_cs", 8'(pad_cs), 8'(CS_DEF));
        chk("rst_din", 8'(din), 8'd0);

        for (int i = 0; i < 9; i++) begin
            req = tbl[i].req; dir_out = tbl[i].dir; dout = tbl[i].dout; pull_cfg = tbl[i].pull;
            tick();
            chk($sformatf("vec%0d_gnt", i), 8'(gnt), 8'(tbl[i].g));
            chk($sformatf("vec%0d_busy", i), 8'(busy), 8'(tbl[i].bsy));
            chk($sformatf("vec%0d_oe", i), 8'(pad_oe), 8'(tbl[i].oe));
            chk($sformatf("vec%0d_a", i), 8'(pad_a), 8'(tbl[i].a));
            chk($sformatf("vec%0d_pd", i), 8'(pad_pd), 8'(tbl[i].pd));
            chk($sformatf("vec%0d_pu", i), 8'(pad_pu), 8'(tbl[i].pu));
        end

        pad_y = 1'b1; tick(); chk("din_lat1", 8'(din), 8'd0);
        tick(); chk("din_lat2", 8'(din), 8'd1);
        pad_y = 1'b0; tick(); chk("din_fall1", 8'(din), 8'd1);
        tick(); chk("din_fall2", 8'(din), 8'd0);

        req = '1; dir_out = '1; dout = '0; pull_cfg = '0;
        do_reset();
        run = 0; gap = 0; last = '0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (gnt != '0) begin
                if (gnt != last) begin
                    ord.push_back(idx_of(gnt));
                    if (ord.size() > 1) gaps.push_back(gap);
                    run = 0; gap = 0; last = gnt;
                end
                run++;
                if (run == 5) req = req & ~gnt;
            end else if (ord.size() > 0 && !pad_oe) begin
                gap++;
            end
        end
        chk("rr_owners", 8'(ord.size()), 8'd4);
        for (int i = 0; i < 4; i++) if (i < ord.size()) chk($sformatf("rr_order%0d", i), 8'(ord[i]), 8'(i));
        chk("rr_ngaps", 8'(gaps.size()), 8'd3);
        foreach (gaps[i]) chk($sformatf("rr_gap%0d", i), 8'(gaps[i]), 8'(TURN_CYC));

        req = '0; dir_out = 4'b0001; dout = '0;
        do_reset();
        req = 4'b0001;
        tick(); t = 1;
        while (gnt != 4'b0001 && t < 5) begin tick(); t++; end
        own = (gnt == 4'b0001) ? 1 : 0;
        t = 0;
        while (gnt == 4'b0001 && t < 40) begin
            if (own == 3) req[2] = 1'b1;
            tick(); t++;
            if (gnt == 4'b0001) own++;
        end
        chk("pre_hold", 8'(own), 8'(MAX_HOLD));
        gap = 0; t = 0;
        while (gnt == '0 && t < 10) begin gap++; tick(); t++; end
        chk("pre_gap", 8'(gap), 8'(TURN_CYC));
        chk("pre_gnt2", 8'(gnt), 8'b0100);
        n2 = 0;
        repeat (4) begin tick(); if (gnt == 4'b0100) n2++; end
        chk("pre_keep2", 8'(n2), 8'd4);
        req[2] = 1'b0;
        tick();
        gap = 0; t = 0;
        while (gnt == '0 && t < 10) begin gap++; tick(); t++; end
        chk("ret_gap", 8'(gap), 8'(TURN_CYC));
        chk("ret_gnt0", 8'(gnt), 8'b0001);

        req = 4'b0010; dir_out = 4'b0010; dout = 4'b0010;
        do_reset();
        repeat (3) tick();
        chk("arst_oe_pre", 8'(pad_oe), 8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_oe", 8'(pad_oe), 8'd0);
        chk("arst_gnt", 8'(gnt), 8'd0);
        chk("arst_busy", 8'(busy), 8'd0);
        req = 4'b1111;
        do_reset();
        tick();
        chk("arst_first", 8'(gnt), 8'b0001);

        req = '0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) if ($urandom_range(11) == 0) req[i] = ~req[i];
            dir_out  = NREQ'($urandom);
            dout     = NREQ'($urandom);
            pull_cfg = (2*NREQ)'($urandom);
            pad_y    = 1'($urandom_range(1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
